pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline-stage register with valid/ready handshake, stall support and synchronous flush, the general-purpose replacement for the fixed-format inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque payload of configurable width between two pipeline stages. A flush inserts a bubble, and back-pressure from the downstream stage stalls the upstream stage without losing data. An optional skid entry registers `ready_o` so stall paths do not chain combinationally across stages.

## Interface
- `WIDTH`, default 32: payload width in bits. Must be ≥ 1.
- `ZERO_ON_FLUSH`, default 1: when 1, flush and reset force stored payload to 0. When 0, payload registers keep their contents and only valid bits clear.
- `CLK_i` input 1: single clock; all state updates on its rising edge.
- `RST_i` input 1: reset, synchronous, active-high.
- `flush_i` input 1: synchronous flush; discards all held entries and the incoming beat.
- `valid_i` input 1: upstream presents a beat.
- `data_i` input WIDTH: upstream payload.
- `ready_o` output 1: stage can accept a beat this cycle.
- `valid_o` output 1: `data_o` holds a valid beat.
- `data_o` output WIDTH: payload to the downstream stage.
- `ready_i` input 1: downstream accepts `data_o` this cycle.

## Operation
- Input transfer: `valid_i && ready_o` at a rising edge. Output transfer: `valid_o && ready_i` at a rising edge.
- Storage: main entry (`valid_o`/`data_o` registers). With `PIPE_SKID_EN`, also one skid entry (`skid_v`/`skid_d`).
- States without skid:
  - EMPTY (`valid_o`=0)
  - FULL (`valid_o`=1)
- States with skid:
  - EMPTY
  - FULL: main valid, skid empty.
  - SKID: both valid.
- Transitions with skid, no flush:
  - EMPTY + in → FULL.
  - FULL + in + out → FULL. Main loads `data_i`.
  - FULL + in, no out → SKID. Skid loads `data_i`.
  - FULL + out, no in → EMPTY.
  - SKID + out → FULL. Main loads skid. Input is impossible in SKID because `ready_o`=0.
- Transitions without skid: main loads `data_i` on every input transfer. It clears `valid_o` on an output transfer that has no simultaneous input.
- Flush, highest priority after reset:
  - The next state is EMPTY and `skid_v`=0.
  - A beat offered with `valid_i` in the flush cycle is dropped.
  - An output transfer in the flush cycle still completes, because the downstream stage sampled `data_o`.
  - If `ZERO_ON_FLUSH`=1, `data_o` and `skid_d` are set to 0.
- Reset has the same effect as flush, and `data_o` is always zeroed regardless of `ZERO_ON_FLUSH`.
- Ordering is strictly FIFO. No beat is duplicated or lost except by flush.

## Timing
- Latency is 1 cycle from input transfer to `valid_o`, whether the stage was EMPTY or FULL-with-drain.
- Throughput is 1 beat/cycle while `ready_i`=1 continuously.
- Values in and after reset:
  - `valid_o`=0 and `data_o`=0 from the first edge with `RST_i`=1.
  - `ready_o`=1 in the cycle after reset deasserts.
  - While `RST_i`=1, `ready_o`=0.
- `ready_o` without skid is `!RST_i && (!valid_o || ready_i)`. This is combinational from `ready_i`.
- `ready_o` with skid is `!RST_i && !skid_v`. It depends only on registers, so there is no `ready_i` → `ready_o` path.
- Stall with skid: when `ready_i` drops while FULL, exactly one more beat is absorbed. `ready_o` falls on the following cycle.
- `valid_o`/`data_o` must stay stable while `valid_o && !ready_i`, except when flush or reset clears them.

## Configuration
- `PIPE_SKID_EN`:
  - Defined: skid entry present, three-state operation, `ready_o` registered.
  - Undefined: two-state operation, no skid registers, combinational `ready_o`, less area.
- Port list and latency are identical in both builds.

## Structure
- State encodings `PIPE_ST_EMPTY`=2'd0, `PIPE_ST_FULL`=2'd1 and `PIPE_ST_SKID`=2'd2 go in `include/lagartoII_const.vh`. The payload width macro `WORD` also lives there and is reused as the `WIDTH` default.
- The skid entry is a natural sub-module, `pipe_skid_buf`, holding `skid_v`/`skid_d` with load and clear controls. It is instantiated only under `PIPE_SKID_EN`.

## Test plan
All scenarios use WIDTH=32.
- Reset: hold `RST_i` 2 cycles with `valid_i`=1, `data_i`=32'hDEADBEEF. Expected: `valid_o`=0 and `data_o`=0 throughout, and `ready_o`=1 one cycle after release.
- Streaming: `ready_i`=1, beats 1..8 on consecutive cycles. Expected: `data_o`=1..8 on consecutive cycles, each 1 cycle after input, with no gaps.
- Back-pressure (skid): stream 10,11,12 and drop `ready_i` as 10 is presented. Expected:
  - `ready_o` falls after 11 is absorbed.
  - `data_o` holds 10 stably.
  - On `ready_i`=1, the output is 10,11 then 12 with none lost.
- Flush while SKID: main=32'h20, skid=32'h21, `valid_i`=1 with 32'h22, `flush_i`=1, `ready_i`=0. Expected: next cycle `valid_o`=0, `data_o`=0, `ready_o`=1, and 32'h22 is never output.
- Flush with output transfer: `valid_o`=1, `data_o`=32'h30, `ready_i`=1, `flush_i`=1. Expected: the consumer receives 32'h30 once, then `valid_o`=0.
- `ZERO_ON_FLUSH`=0: same stimulus as the previous flush scenario. Expected: `valid_o`=0 and `data_o` retains 32'h30.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for pipe_stage_reg: occupancy state encodings and the default payload width.
package pipe_stage_reg_pkg;

    localparam int WORD = 32;

    typedef enum logic [1:0] {
        PIPE_ST_EMPTY = 2'd0,
        PIPE_ST_FULL  = 2'd1,
        PIPE_ST_SKID  = 2'd2
    } pipeState_t;

    function automatic logic isOccupied(input pipeState_t st);
        return st != PIPE_ST_EMPTY;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid register: catches the beat accepted in the cycle the downstream stalls,
// which lets the owning stage drive ready_o straight from a flop.
module pipe_skid_buf #(
    parameter int WIDTH         = 32,
    parameter bit ZERO_ON_FLUSH = 1'b1
) (
    input  logic             CLK_i,
    input  logic             RST_i,
    input  logic             load,
    input  logic             drain,
    input  logic             flush,
    input  logic [WIDTH-1:0] dataIn,
    output logic             skidV,
    output logic [WIDTH-1:0] skidD
);

    function automatic logic [WIDTH-1:0] flushData(input logic [WIDTH-1:0] held);
        return ZERO_ON_FLUSH ? '0 : held;
    endfunction

    always_ff @(posedge CLK_i) begin
        if (RST_i || flush) begin
            skidV <= 1'b0;
        end else if (load) begin
            skidV <= 1'b1;
        end else if (drain) begin
            skidV <= 1'b0;
        end
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            skidD <= '0;
        end else if (flush) begin
            skidD <= flushData(skidD);
        end else if (load) begin
            skidD <= dataIn;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, stall and synchronous flush.
// Build option PIPE_SKID_EN adds a skid entry so ready_o has no combinational path from ready_i.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int WIDTH         = WORD,
    parameter bit ZERO_ON_FLUSH = 1'b1
) (
    input  logic             CLK_i,
    input  logic             RST_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    input  logic             ready_i
);

    pipeState_t       stateP0;
    pipeState_t       stateNext;
    logic [WIDTH-1:0] dataP0;
    logic [WIDTH-1:0] mainNext;
    logic             mainLoad;
    logic             inXfer;
    logic             outXfer;

`ifdef PIPE_SKID_EN
    logic             skidLoad;
    logic             skidDrain;
    logic             skidV;
    logic [WIDTH-1:0] skidD;
`endif

    function automatic logic [WIDTH-1:0] flushData(input logic [WIDTH-1:0] held);
        return ZERO_ON_FLUSH ? '0 : held;
    endfunction

    assign valid_o = isOccupied(stateP0);
    assign data_o  = dataP0;
    assign inXfer  = valid_i && ready_o;
    assign outXfer = valid_o && ready_i;

`ifdef PIPE_SKID_EN
    assign ready_o = !RST_i && !skidV;
`else
    assign ready_o = !RST_i && (!valid_o || ready_i);
`endif

    always_comb begin
        stateNext = stateP0;
        mainLoad  = 1'b0;
        mainNext  = data_i;
`ifdef PIPE_SKID_EN
        skidLoad  = 1'b0;
        skidDrain = 1'b0;
`endif
        unique case (stateP0)
            PIPE_ST_EMPTY: begin
                if (inXfer) begin
                    stateNext = PIPE_ST_FULL;
                    mainLoad  = 1'b1;
                end
            end
            PIPE_ST_FULL: begin
`ifdef PIPE_SKID_EN
                if (inXfer && !outXfer) begin
                    stateNext = PIPE_ST_SKID;
                    skidLoad  = 1'b1;
                end else if (inXfer) begin
                    mainLoad = 1'b1;
                end else if (outXfer) begin
                    stateNext = PIPE_ST_EMPTY;
                end
`else
                // Without a skid entry an accepted beat in FULL always coincides with a drain.
                if (inXfer) begin
                    mainLoad = 1'b1;
                end else if (outXfer) begin
                    stateNext = PIPE_ST_EMPTY;
                end
`endif
            end
            PIPE_ST_SKID: begin
`ifdef PIPE_SKID_EN
                if (outXfer) begin
                    stateNext = PIPE_ST_FULL;
                    mainLoad  = 1'b1;
                    mainNext  = skidD;
                    skidDrain = 1'b1;
                end
`else
                stateNext = PIPE_ST_EMPTY;
`endif
            end
            default: stateNext = PIPE_ST_EMPTY;
        endcase

        // Flush drops held and incoming beats; a concurrent output transfer has already been sampled.
        if (flush_i) begin
            stateNext = PIPE_ST_EMPTY;
            mainLoad  = 1'b0;
`ifdef PIPE_SKID_EN
            skidLoad  = 1'b0;
            skidDrain = 1'b0;
`endif
        end
    end

    // ---- stage p0: main entry ----
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            stateP0 <= PIPE_ST_EMPTY;
        end else begin
            stateP0 <= stateNext;
        end
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            dataP0 <= '0;
        end else if (flush_i) begin
            dataP0 <= flushData(dataP0);
        end else if (mainLoad) begin
            dataP0 <= mainNext;
        end
    end

`ifdef PIPE_SKID_EN
    pipe_skid_buf #(
        .WIDTH         (WIDTH),
        .ZERO_ON_FLUSH (ZERO_ON_FLUSH)
    ) skidBuf (
        .CLK_i  (CLK_i),
        .RST_i  (RST_i),
        .load   (skidLoad),
        .drain  (skidDrain),
        .flush  (flush_i),
        .dataIn (data_i),
        .skidV  (skidV),
        .skidD  (skidD)
    );
`endif

    holdWhileStalled: assert property (@(posedge CLK_i) disable iff (RST_i)
        (valid_o && !ready_i && !flush_i) |=> (valid_o && $stable(data_o)));

    noReadyInReset: assert property (@(posedge CLK_i) RST_i |-> !ready_o);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised and directed bench for pipe_stage_reg, checked against a queue-based occupancy model.
module tb_pipe_stage_reg;

`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        CLK_i = 1'b0;
    logic        RST_i;
    logic        flush_i;
    logic        valid_i;
    logic        ready_i;
    logic [31:0] data_i;

    logic        readyZ, validZ;
    logic [31:0] dataZ;
    logic        readyK, validK;
    logic [31:0] dataK;

    int checks   = 0;
    int failures = 0;

    logic [31:0] modelQ[$];
    logic [31:0] shownZ;
    logic [31:0] shownK;
    logic [31:0] gotQ[$];
    logic        lastAcc;

    always #5 CLK_i = ~CLK_i;

    pipe_stage_reg #(.WIDTH(32), .ZERO_ON_FLUSH(1'b1)) dutZero (
        .CLK_i(CLK_i), .RST_i(RST_i), .flush_i(flush_i), .valid_i(valid_i), .data_i(data_i),
        .ready_o(readyZ), .valid_o(validZ), .data_o(dataZ), .ready_i(ready_i)
    );

    pipe_stage_reg #(.WIDTH(32), .ZERO_ON_FLUSH(1'b0)) dutKeep (
        .CLK_i(CLK_i), .RST_i(RST_i), .flush_i(flush_i), .valid_i(valid_i), .data_i(data_i),
        .ready_o(readyK), .valid_o(validK), .data_o(dataK), .ready_i(ready_i)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Capacity is one beat, plus one more when the skid entry exists.
    function automatic logic modelValid();
        return modelQ.size() > 0;
    endfunction

    function automatic logic modelReady();
        if (RST_i) return 1'b0;
        if (SKID) return modelQ.size() < 2;
        return (modelQ.size() == 0) || ready_i;
    endfunction

    task automatic modelEdge(input logic inX, input logic outX, input logic rst, input logic fl,
                             input logic [31:0] din);
        if (rst) begin
            modelQ.delete();
            shownZ = '0;
            shownK = '0;
        end else if (fl) begin
            modelQ.delete();
            shownZ = '0;
        end else begin
            if (outX) void'(modelQ.pop_front());
            if (inX) modelQ.push_back(din);
            if (modelQ.size() > 0) begin
                shownZ = modelQ[0];
                shownK = modelQ[0];
            end
        end
    endtask

    task automatic tick();
        logic inX, outX, rst, fl;
        logic [31:0] din;
        @(negedge CLK_i);
        checkVal("validZ", 32'(validZ), 32'(modelValid()));
        checkVal("readyZ", 32'(readyZ), 32'(modelReady()));
        checkVal("dataZ",  dataZ, shownZ);
        checkVal("validK", 32'(validK), 32'(modelValid()));
        checkVal("readyK", 32'(readyK), 32'(modelReady()));
        checkVal("dataK",  dataK, shownK);
        inX  = valid_i && modelReady();
        outX = modelValid() && ready_i;
        if (validZ && ready_i) gotQ.push_back(dataZ);
        rst = RST_i;
        fl  = flush_i;
        din = data_i;
        lastAcc = inX;
        @(posedge CLK_i);
        modelEdge(inX, outX, rst, fl, din);
        #1;
    endtask

    initial begin
        logic [31:0] pending[$];

        // reset with a beat offered
        RST_i = 1'b1; flush_i = 1'b0; valid_i = 1'b1; ready_i = 1'b1; data_i = 32'hDEADBEEF;
        @(posedge CLK_i);
        modelEdge(1'b0, 1'b0, 1'b1, 1'b0, '0);
        #1;
        checkVal("rst_valid", 32'(validZ), 32'd0);
        checkVal("rst_data",  dataZ, 32'd0);
        checkVal("rst_ready", 32'(readyZ), 32'd0);
        tick();
        checkVal("rst_valid2", 32'(validZ), 32'd0);
        checkVal("rst_data2",  dataK, 32'd0);
        RST_i = 1'b0; valid_i = 1'b0;
        #1;
        checkVal("rst_release_ready", 32'(readyZ), 32'd1);

        // streaming
        gotQ.delete();
        ready_i = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            valid_i = (i <= 8);
            data_i  = 32'(i);
            tick();
            if (i <= 8) begin
                checkVal("stream_valid", 32'(validZ), 32'd1);
                checkVal("stream_data",  dataZ, 32'(i));
            end
        end
        checkVal("stream_drained", 32'(validZ), 32'd0);
        checkVal("stream_count", 32'(gotQ.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            checkVal("stream_order", (i < gotQ.size()) ? gotQ[i] : 32'hFFFFFFFF, 32'(i + 1));

        // back-pressure: ready_i drops while 10 is on the output
        gotQ.delete();
        pending = '{32'd10, 32'd11, 32'd12};
        for (int c = 0; c < 10; c++) begin
            ready_i = (c == 0) || (c >= 4);
            valid_i = pending.size() > 0;
            data_i  = (pending.size() > 0) ? pending[0] : 32'd0;
            if (c == 1) begin
                #1;
                checkVal("bp_ready_at_drop", 32'(readyZ), SKID ? 32'd1 : 32'd0);
            end
            tick();
            if (lastAcc) void'(pending.pop_front());
            if (c >= 1 && c <= 3) begin
                checkVal("bp_hold_valid", 32'(validZ), 32'd1);
                checkVal("bp_hold_data",  dataZ, 32'd10);
                checkVal("bp_ready_low",  32'(readyZ), 32'd0);
            end
        end
        checkVal("bp_count", 32'(gotQ.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            checkVal("bp_order", (i < gotQ.size()) ? gotQ[i] : 32'hFFFFFFFF, 32'(10 + i));

        // flush while holding two beats (one when no skid entry)
        gotQ.delete();
        ready_i = 1'b0; valid_i = 1'b1; data_i = 32'h20;
        tick();
        data_i = 32'h21;
        tick();
        data_i = 32'h22; flush_i = 1'b1;
        tick();
        flush_i = 1'b0; valid_i = 1'b0;
        #1;
        checkVal("flskid_valid", 32'(validZ), 32'd0);
        checkVal("flskid_data",  dataZ, 32'd0);
        checkVal("flskid_ready", 32'(readyZ), 32'd1);
        checkVal("flskid_keep",  dataK, 32'h20);
        ready_i = 1'b1;
        repeat (3) tick();
        checkVal("flskid_noout", 32'(gotQ.size()), 32'd0);

        // flush coinciding with an output transfer
        gotQ.delete();
        ready_i = 1'b0; valid_i = 1'b1; data_i = 32'h30;
        tick();
        valid_i = 1'b0; ready_i = 1'b1; flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        checkVal("flout_valid",  32'(validZ), 32'd0);
        checkVal("flout_data",   dataZ, 32'd0);
        checkVal("flout_validK", 32'(validK), 32'd0);
        checkVal("flout_keep",   dataK, 32'h30);
        repeat (2) tick();
        checkVal("flout_count", 32'(gotQ.size()), 32'd1);
        checkVal("flout_beat",  (gotQ.size() > 0) ? gotQ[0] : 32'hFFFFFFFF, 32'h30);

        // randomised traffic with varying stall density
        for (int n = 0; n < 3000; n++) begin
            RST_i   = ($urandom_range(0, 249) == 0);
            flush_i = ($urandom_range(0, 49) == 0);
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 7) < ((n / 500) % 4) + 3);
            data_i  = $urandom;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
